fe_fb_arb: RTL and testbench
============================

Name: fe_fb_arb

Overview:
- Shares the single fetch-buffer request/response port between two requesters: demand fetch from the FE control FSM, and the next-line instruction prefetcher.
- Assigns a tag to every outstanding request and routes each response back to its owner by tag.
- Squashes responses to requests that were in flight when a flush occurred.
- Sits between the FE control/prefetcher and the fetch buffer.

Parameters:
- NUM_TAGS, 4: maximum outstanding fetch-buffer requests. Power of two, at least 2.
- STARVE_MAX, 4: number of consecutive demand grants, made while a prefetch request waits, after which prefetch wins once.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- flush  in  1  nuke_rb1.valid | br_mispred_ex0.valid, driven by the parent
- dmd_req_nnn  in  t_fe_fb_req  demand request (valid, addr, id)
- dmd_gnt_nnn  out  1  demand request accepted this cycle
- pf_req_nnn  in  t_fe_fb_req  prefetch request
- pf_gnt_nnn  out  1  prefetch request accepted this cycle
- arb_fb_req_nnn  out  t_fe_fb_req  request to the fetch buffer; id = allocated tag
- fb_rdy_nnn  in  1  fetch buffer can accept a request this cycle
- fb_arb_rsp_nnn  in  t_fb_fe_rsp  fetch buffer response (valid, instr, pc, id = tag)
- dmd_rsp_nnn  out  t_fb_fe_rsp  response to demand; id restored to the requester's id
- pf_rsp_nnn  out  t_fb_fe_rsp  response to prefetch
- busy  out  1  at least one tag allocated

Behaviour:
- Tag table: NUM_TAGS entries of {alloc, owner (0 = demand, 1 = prefetch), stale, orig_id}. All fields are registered.
- Grant condition: fb_rdy_nnn & ~flush & a free tag exists in the registered free vector. Free tag = lowest-index entry with alloc == 0.
- Priority: demand wins, unless starve_cnt == STARVE_MAX and pf_req_nnn.valid, in which case prefetch wins.
- At most one grant per cycle.
- Grant and arb_fb_req_nnn are combinational in the request cycle (zero latency). arb_fb_req_nnn.valid equals the OR of the grants. addr comes from the winner; id = tag zero-extended.
- On grant, at the clock edge: entry[tag] gets alloc = 1, stale = 0, owner, orig_id.
- starve_cnt (width $clog2(STARVE_MAX+1)):
  - increments on a demand grant while pf_req_nnn.valid, saturating at STARVE_MAX;
  - clears on a prefetch grant or when pf_req_nnn.valid == 0.
- Response: look up entry[fb_arb_rsp_nnn.id].
  - If alloc & ~stale & ~flush: drive the owner's rsp output combinationally that cycle (instr, pc, id = orig_id); the other rsp output stays 0.
  - Otherwise drop the response (both outputs 0).
  - In both cases clear alloc at the edge.
- A tag freed in cycle N can be allocated no earlier than cycle N+1, because allocation uses registered state.
- Flush: at the edge, every entry with alloc == 1 gets stale = 1. No grant is made in the flush cycle. A response arriving in the flush cycle is dropped.
- Full: all tags allocated, so both gnt = 0 and arb_fb_req_nnn.valid = 0, even when fb_rdy_nnn is high.
- Requesters hold valid/addr until granted. Deasserting before grant is legal.
- Reset (async assert, sync deassert by the parent): table cleared, starve_cnt = 0.
  - Outputs during and after reset: gnt = 0, arb_fb_req_nnn = 0, rsp outputs = 0, busy = 0.
  - Reset mid-flight: responses to pre-reset tags find alloc == 0 and are dropped.
- Assertions:
  - a response carrying a tag with alloc == 0 outside the first NUM_TAGS cycles after reset;
  - dmd_gnt_nnn & pf_gnt_nnn.

Optional Feature:
- FE_FB_ARB_PERF_EN: adds 32-bit saturating counters, cleared by reset: dmd_grants, pf_grants, stale_drops, full_stall_cycles (a request is valid but all tags are allocated).
- The counters are exposed as a perf_cnt output struct.
- Without the macro, neither the counters nor the port exist.

Decomposition:
- The mem_common package gets:
  - constant FE_FB_NUM_TAGS;
  - t_fe_fb_tag (logic[$clog2(FE_FB_NUM_TAGS)-1:0]);
  - t_fe_fb_owner enum {FB_OWN_DMD, FB_OWN_PF};
  - t_fe_fb_arb_perf struct.
- t_fe_fb_req and t_fb_fe_rsp are reused unchanged; their id field is at least tag width.
- One sub-module, fe_fb_tag_tbl: holds the entry storage, the lowest-free-tag priority encoder, and alloc/free/flush-stale updates.
- The top level holds arbitration, starve_cnt and response routing.

Test Plan:
- Demand only, addr 0x100, id 3, fb_rdy=1 → dmd_gnt=1 in the same cycle, arb req id=0. Response on tag 0 → dmd_rsp valid, id=3, pc=0x100.
- Both requesters held valid, fb_rdy=1, NUM_TAGS large enough, responses returned promptly → grant sequence D,D,D,D,P,D… (prefetch wins on the 5th grant). starve_cnt returns to 0 after the prefetch grant.
- Issue 4 requests with no responses → 5th request sees gnt=0 and busy=1. Return tag 2 → the 5th request is granted the next cycle with tag 2.
- Allocate tags 0 and 1, pulse flush, then return both responses → both dropped, rsp outputs stay 0, tags freed. A new demand after flush is granted tag 0.
- Flush in the same cycle as a valid request and a response → no grant, response dropped. Request granted the cycle after.
- Assert reset with 3 tags allocated, deassert, return tag 1 response → response dropped, assertion fires only outside the post-reset window, busy=0.

Source files
------------

// File: rtl/fe_fb_arb_pkg.sv
// Shared types for the front-end fetch-buffer arbiter: tags, owners, request/response and perf structs.
package fe_fb_arb_pkg;

    localparam int FE_FB_NUM_TAGS = 4;
    localparam int FE_FB_ID_W     = 4;

    typedef logic [$clog2(FE_FB_NUM_TAGS)-1:0] t_fe_fb_tag;

    typedef enum logic {
        FB_OWN_DMD = 1'b0,
        FB_OWN_PF  = 1'b1
    } t_fe_fb_owner;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           addr;
        logic [FE_FB_ID_W-1:0] id;
    } t_fe_fb_req;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           instr;
        logic [31:0]           pc;
        logic [FE_FB_ID_W-1:0] id;
    } t_fb_fe_rsp;

    typedef struct packed {
        logic [31:0] dmd_grants;
        logic [31:0] pf_grants;
        logic [31:0] stale_drops;
        logic [31:0] full_stall_cycles;
    } t_fe_fb_arb_perf;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fe_fb_arb_chk.sv
// Protocol checker for fe_fb_arb: single grant per cycle, and no responses to unallocated tags
// once the post-reset window (responses to pre-reset tags may still arrive) has elapsed.
module fe_fb_arb_chk #(
    parameter int NUM_TAGS = 4
) (
    input logic clk,
    input logic reset,
    input logic rsp_valid,
    input logic rsp_alloc,
    input logic dmd_gnt,
    input logic pf_gnt
);

    localparam int CW = $clog2(NUM_TAGS + 1);

    logic [CW-1:0] win_cnt_r;

    // Counts cycles since reset release, saturating at NUM_TAGS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_r <= '0;
        end else if (win_cnt_r != CW'(NUM_TAGS)) begin
            win_cnt_r <= win_cnt_r + CW'(1);
        end
    end

    a_rsp_unalloc: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_valid && !rsp_alloc && (win_cnt_r == CW'(NUM_TAGS))));

    a_one_gnt: assert property (@(posedge clk) disable iff (!reset)
        !(dmd_gnt && pf_gnt));

endmodule

// File: rtl/fe_fb_tag_tbl.sv
// Outstanding-request tag table: per-tag {alloc, owner, stale, orig_id}, lowest-free encoder,
// alloc/free updates and flush marking of in-flight tags as stale.
module fe_fb_tag_tbl
    import fe_fb_arb_pkg::*;
#(
    parameter int NUM_TAGS = FE_FB_NUM_TAGS,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alloc_en,
    input  t_fe_fb_owner          alloc_owner,
    input  logic [FE_FB_ID_W-1:0] alloc_orig_id,
    input  logic                  free_en,
    input  logic [TAG_W-1:0]      lk_tag,
    output logic                  free_avail,
    output logic [TAG_W-1:0]      free_tag,
    output logic                  lk_alloc,
    output logic                  lk_stale,
    output t_fe_fb_owner          lk_owner,
    output logic [FE_FB_ID_W-1:0] lk_orig_id,
    output logic                  busy
);

    logic [NUM_TAGS-1:0]   alloc_r;
    logic [NUM_TAGS-1:0]   stale_r;
    logic [NUM_TAGS-1:0]   owner_r;
    logic [FE_FB_ID_W-1:0] orig_id_r [NUM_TAGS];
    logic [NUM_TAGS-1:0]   alloc_nx_s;
    logic [NUM_TAGS-1:0]   stale_nx_s;

    // Lowest-index free tag; scanning downward lets the lowest index win.
    always_comb begin
        free_avail = 1'b0;
        free_tag   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!alloc_r[i]) begin
                free_avail = 1'b1;
                free_tag   = TAG_W'(i);
            end else begin
                free_avail = free_avail;
            end
        end
    end

    // Next-state of alloc/stale: flush marks, then free, then allocation wins on the same entry.
    always_comb begin
        alloc_nx_s = alloc_r;
        stale_nx_s = stale_r;
        if (flush) begin
            stale_nx_s = stale_r | alloc_r;
        end else begin
            stale_nx_s = stale_r;
        end
        if (free_en) begin
            alloc_nx_s[lk_tag] = 1'b0;
        end else begin
            alloc_nx_s = alloc_nx_s;
        end
        if (alloc_en) begin
            alloc_nx_s[free_tag] = 1'b1;
            stale_nx_s[free_tag] = 1'b0;
        end else begin
            alloc_nx_s = alloc_nx_s;
        end
    end

    // Table storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alloc_r <= '0;
            stale_r <= '0;
            owner_r <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                orig_id_r[i] <= '0;
            end
        end else begin
            alloc_r <= alloc_nx_s;
            stale_r <= stale_nx_s;
            if (alloc_en) begin
                owner_r[free_tag]   <= alloc_owner;
                orig_id_r[free_tag] <= alloc_orig_id;
            end
        end
    end

    assign lk_alloc   = alloc_r[lk_tag];
    assign lk_stale   = stale_r[lk_tag];
    assign lk_owner   = t_fe_fb_owner'(owner_r[lk_tag]);
    assign lk_orig_id = orig_id_r[lk_tag];
    assign busy       = |alloc_r;

endmodule

// File: rtl/fe_fb_arb.sv
// Demand/prefetch arbiter for the fetch-buffer port with tag-based response routing and flush squash.
// Optional FE_FB_ARB_PERF_EN adds saturating perf counters on a perf_cnt port.
module fe_fb_arb
    import fe_fb_arb_pkg::*;
#(
    parameter int NUM_TAGS   = FE_FB_NUM_TAGS,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  t_fe_fb_req      dmd_req_nnn,
    output logic            dmd_gnt_nnn,
    input  t_fe_fb_req      pf_req_nnn,
    output logic            pf_gnt_nnn,
    output t_fe_fb_req      arb_fb_req_nnn,
    input  logic            fb_rdy_nnn,
    input  t_fb_fe_rsp      fb_arb_rsp_nnn,
    output t_fb_fe_rsp      dmd_rsp_nnn,
    output t_fb_fe_rsp      pf_rsp_nnn,
    output logic            busy
`ifdef FE_FB_ARB_PERF_EN
    ,
    output t_fe_fb_arb_perf perf_cnt
`endif
);

    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic                  free_avail_s;
    logic [TAG_W-1:0]      free_tag_s;
    logic                  can_grant_s;
    logic                  pf_pri_s;
    logic                  dmd_gnt_s;
    logic                  pf_gnt_s;
    logic [TAG_W-1:0]      lk_tag_s;
    logic                  tag_ok_s;
    logic                  lk_alloc_s;
    logic                  lk_stale_s;
    t_fe_fb_owner          lk_owner_s;
    logic [FE_FB_ID_W-1:0] lk_orig_id_s;
    logic                  deliver_s;
    logic                  free_en_s;
    logic [CNT_W-1:0]      starve_cnt_r;

    // Ids with bits above the tag width can never match an entry; treat them as unallocated.
    assign lk_tag_s  = fb_arb_rsp_nnn.id[TAG_W-1:0];
    assign tag_ok_s  = (fb_arb_rsp_nnn.id >> TAG_W) == '0;
    assign free_en_s = fb_arb_rsp_nnn.valid & tag_ok_s;

    fe_fb_tag_tbl #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_tag_tbl (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .alloc_en      (dmd_gnt_s | pf_gnt_s),
        .alloc_owner   (pf_gnt_s ? FB_OWN_PF : FB_OWN_DMD),
        .alloc_orig_id (pf_gnt_s ? pf_req_nnn.id : dmd_req_nnn.id),
        .free_en       (free_en_s),
        .lk_tag        (lk_tag_s),
        .free_avail    (free_avail_s),
        .free_tag      (free_tag_s),
        .lk_alloc      (lk_alloc_s),
        .lk_stale      (lk_stale_s),
        .lk_owner      (lk_owner_s),
        .lk_orig_id    (lk_orig_id_s),
        .busy          (busy)
    );

    // Reset gating keeps grants low while the parent holds the block in reset.
    assign can_grant_s = reset & fb_rdy_nnn & ~flush & free_avail_s;
    assign pf_pri_s    = (starve_cnt_r == CNT_W'(STARVE_MAX)) & pf_req_nnn.valid;

    // Grant selection: demand first unless prefetch has been starved.
    always_comb begin
        dmd_gnt_s = 1'b0;
        pf_gnt_s  = 1'b0;
        if (can_grant_s && pf_pri_s) begin
            pf_gnt_s = 1'b1;
        end else if (can_grant_s && dmd_req_nnn.valid) begin
            dmd_gnt_s = 1'b1;
        end else if (can_grant_s && pf_req_nnn.valid) begin
            pf_gnt_s = 1'b1;
        end else begin
            dmd_gnt_s = 1'b0;
        end
    end

    // Outgoing fetch-buffer request carries the allocated tag as its id.
    always_comb begin
        arb_fb_req_nnn = '0;
        if (dmd_gnt_s) begin
            arb_fb_req_nnn.valid = 1'b1;
            arb_fb_req_nnn.addr  = dmd_req_nnn.addr;
            arb_fb_req_nnn.id    = FE_FB_ID_W'(free_tag_s);
        end else if (pf_gnt_s) begin
            arb_fb_req_nnn.valid = 1'b1;
            arb_fb_req_nnn.addr  = pf_req_nnn.addr;
            arb_fb_req_nnn.id    = FE_FB_ID_W'(free_tag_s);
        end else begin
            arb_fb_req_nnn = '0;
        end
    end

    assign dmd_gnt_nnn = dmd_gnt_s;
    assign pf_gnt_nnn  = pf_gnt_s;
    assign deliver_s   = free_en_s & lk_alloc_s & ~lk_stale_s & ~flush;

    // Route a live response to its owner with the requester's original id restored.
    always_comb begin
        dmd_rsp_nnn = '0;
        pf_rsp_nnn  = '0;
        if (deliver_s && (lk_owner_s == FB_OWN_PF)) begin
            pf_rsp_nnn.valid = 1'b1;
            pf_rsp_nnn.instr = fb_arb_rsp_nnn.instr;
            pf_rsp_nnn.pc    = fb_arb_rsp_nnn.pc;
            pf_rsp_nnn.id    = lk_orig_id_s;
        end else if (deliver_s) begin
            dmd_rsp_nnn.valid = 1'b1;
            dmd_rsp_nnn.instr = fb_arb_rsp_nnn.instr;
            dmd_rsp_nnn.pc    = fb_arb_rsp_nnn.pc;
            dmd_rsp_nnn.id    = lk_orig_id_s;
        end else begin
            dmd_rsp_nnn = '0;
        end
    end

    // Starvation counter: demand grants made while prefetch waits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= '0;
        end else if (pf_gnt_s || !pf_req_nnn.valid) begin
            starve_cnt_r <= '0;
        end else if (dmd_gnt_s && (starve_cnt_r != CNT_W'(STARVE_MAX))) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end
    end

    fe_fb_arb_chk #(
        .NUM_TAGS (NUM_TAGS)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .rsp_valid (free_en_s),
        .rsp_alloc (lk_alloc_s),
        .dmd_gnt   (dmd_gnt_s),
        .pf_gnt    (pf_gnt_s)
    );

`ifdef FE_FB_ARB_PERF_EN
    t_fe_fb_arb_perf perf_r;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_r <= '0;
        end else begin
            if (dmd_gnt_s) perf_r.dmd_grants <= sat_inc32(perf_r.dmd_grants);
            if (pf_gnt_s) perf_r.pf_grants <= sat_inc32(perf_r.pf_grants);
            if (fb_arb_rsp_nnn.valid && !deliver_s) perf_r.stale_drops <= sat_inc32(perf_r.stale_drops);
            if ((dmd_req_nnn.valid || pf_req_nnn.valid) && !free_avail_s)
                perf_r.full_stall_cycles <= sat_inc32(perf_r.full_stall_cycles);
        end
    end

    assign perf_cnt = perf_r;
`endif

endmodule

// File: tb/tb_fe_fb_arb.sv
// Self-checking bench for fe_fb_arb: directed cycles with a tag model and a response scoreboard.
module tb_fe_fb_arb;
    import fe_fb_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       fb_rdy;
    t_fe_fb_req dmd_req, pf_req, arb_req;
    logic       dmd_gnt, pf_gnt, busy;
    t_fb_fe_rsp fb_rsp, dmd_rsp, pf_rsp;
`ifdef FE_FB_ARB_PERF_EN
    t_fe_fb_arb_perf perf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        owner;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  id;
    } exp_rsp_t;

    exp_rsp_t    rsp_q[$];
    exp_rsp_t    mon_e;
    t_fb_fe_rsp  mon_r;
    logic        m_alloc [4];
    logic        m_owner [4];
    logic [3:0]  m_id    [4];
    logic [31:0] m_addr  [4];
    int          instr_seq = 0;

    fe_fb_arb dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .dmd_req_nnn    (dmd_req),
        .dmd_gnt_nnn    (dmd_gnt),
        .pf_req_nnn     (pf_req),
        .pf_gnt_nnn     (pf_gnt),
        .arb_fb_req_nnn (arb_req),
        .fb_rdy_nnn     (fb_rdy),
        .fb_arb_rsp_nnn (fb_rsp),
        .dmd_rsp_nnn    (dmd_rsp),
        .pf_rsp_nnn     (pf_rsp),
        .busy           (busy)
`ifdef FE_FB_ARB_PERF_EN
        ,
        .perf_cnt       (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < 4; i++) begin
            if (!m_alloc[i]) return i;
        end
        return -1;
    endfunction

    // One bench cycle: drive at posedge+1, check at negedge, update the model at the next posedge.
    task automatic cyc(input logic dv, input logic [31:0] da, input logic [3:0] di,
                       input logic pv, input logic [31:0] pa, input logic [3:0] pi,
                       input logic rv, input int rt, input logic fl,
                       input logic ed, input logic ep, input logic er,
                       input string nm, output int gtag);
        int          ft;
        exp_rsp_t    e;
        logic [31:0] ins;
        ins = 32'hA500_0000 + instr_seq;
        instr_seq++;
        dmd_req = '{valid: dv, addr: da, id: di};
        pf_req  = '{valid: pv, addr: pa, id: pi};
        flush   = fl;
        fb_rsp  = '{valid: rv, instr: ins, pc: (rv ? m_addr[rt] : 32'h0), id: 4'(rt)};
        ft = lowest_free();
        if (er) begin
            e.owner = m_owner[rt];
            e.instr = ins;
            e.pc    = m_addr[rt];
            e.id    = m_id[rt];
            rsp_q.push_back(e);
        end
        @(negedge clk);
        chk_eq({nm, "_dgnt"}, dmd_gnt, ed);
        chk_eq({nm, "_pgnt"}, pf_gnt, ep);
        chk_eq({nm, "_arbv"}, arb_req.valid, ed | ep);
        gtag = -1;
        if (ed | ep) begin
            chk_eq({nm, "_arbid"}, arb_req.id, 4'(ft));
            chk_eq({nm, "_arbaddr"}, arb_req.addr, ed ? da : pa);
            gtag = ft;
        end
        if (er) begin
            chk_eq({nm, "_rspv"}, dmd_rsp.valid | pf_rsp.valid, 1);
        end else begin
            chk_eq({nm, "_drop_d"}, dmd_rsp.valid, 0);
            chk_eq({nm, "_drop_p"}, pf_rsp.valid, 0);
        end
        @(posedge clk);
        if (rv) m_alloc[rt] = 1'b0;
        if ((ed | ep) && ft >= 0) begin
            m_alloc[ft] = 1'b1;
            m_owner[ft] = ep;
            m_id[ft]    = ed ? di : pi;
            m_addr[ft]  = ed ? da : pa;
        end
        #1;
    endtask

    // Scoreboard: every delivered response must match the oldest expected one.
    always @(negedge clk) begin
        if (reset && (dmd_rsp.valid || pf_rsp.valid)) begin
            if (rsp_q.size() == 0) begin
                chk_eq("rsp_unexpected", rsp_q.size(), 1);
            end else begin
                mon_e = rsp_q.pop_front();
                mon_r = pf_rsp.valid ? pf_rsp : dmd_rsp;
                chk_eq("rsp_both", dmd_rsp.valid & pf_rsp.valid, 0);
                chk_eq("rsp_owner", pf_rsp.valid, mon_e.owner);
                chk_eq("rsp_instr", mon_r.instr, mon_e.instr);
                chk_eq("rsp_pc", mon_r.pc, mon_e.pc);
                chk_eq("rsp_id", mon_r.id, mon_e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int prev;
        int drain [4];
        logic ep_i;
        reset = 1'b0; flush = 1'b0; fb_rdy = 1'b1;
        pf_req = '0; fb_rsp = '0;
        dmd_req = '{valid: 1'b1, addr: 32'h40, id: 4'h1};
        for (int i = 0; i < 4; i++) begin
            m_alloc[i] = 1'b0; m_owner[i] = 1'b0; m_id[i] = 4'h0; m_addr[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_dgnt", dmd_gnt, 0);
        chk_eq("rst_arb", arb_req, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_drsp", dmd_rsp.valid, 0);
        chk_eq("rst_prsp", pf_rsp.valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        dmd_req = '0;

        // Demand only, then its response.
        cyc(1, 32'h100, 4'h3, 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, "dmd", g);
        chk_eq("dmd_tag", g, 0);
        chk_eq("dmd_busy", busy, 1);
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0, 1, "dmd_rsp", g);
        chk_eq("idle_busy", busy, 0);

        fb_rdy = 1'b0;
        cyc(1, 32'h140, 4'h1, 1, 32'h900, 4'h2, 0, 0, 0, 0, 0, 0, "nordy", g);
        fb_rdy = 1'b1;

        // Starvation pattern D,D,D,D,P repeated.
        prev = -1;
        for (int i = 0; i < 10; i++) begin
            ep_i = ((i % 5) == 4);
            cyc(1, 32'h200, 4'h5, 1, 32'h800, 4'h9, prev >= 0, (prev < 0) ? 0 : prev, 0,
                !ep_i, ep_i, prev >= 0, $sformatf("arb%0d", i), g);
            prev = g;
        end
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, prev, 0, 0, 0, 1, "arb_end", g);

        // Fill all tags, stall, free tag 2, regrant tag 2 the following cycle.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h300 + i * 16, 4'(i), 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, $sformatf("fill%0d", i), g);
            chk_eq("fill_tag", g, i);
        end
        cyc(1, 32'h340, 4'h7, 1, 32'h940, 4'h8, 0, 0, 0, 0, 0, 0, "full", g);
        chk_eq("full_busy", busy, 1);
        cyc(1, 32'h340, 4'h7, 0, 32'h0, 4'h0, 1, 2, 0, 0, 0, 1, "free_same", g);
        cyc(1, 32'h340, 4'h7, 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, "regrant", g);
        chk_eq("regrant_tag", g, 2);
        drain = '{0, 1, 3, 2};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, drain[i], 0, 0, 0, 1, $sformatf("drain%0d", i), g);
        end

        // Flush squashes both in-flight responses.
        cyc(1, 32'h400, 4'h2, 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, "fl_a", g);
        cyc(0, 32'h0, 4'h0, 1, 32'h410, 4'h3, 0, 0, 0, 0, 1, 0, "fl_b", g);
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, "fl_pulse", g);
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0, 0, "fl_r0", g);
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 1, 0, 0, 0, 0, "fl_r1", g);
        chk_eq("fl_busy", busy, 0);
        cyc(1, 32'h420, 4'h4, 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, "fl_new", g);
        chk_eq("fl_new_tag", g, 0);
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0, 1, "fl_new_rsp", g);

        // Flush coinciding with a request and a response.
        cyc(1, 32'h500, 4'h1, 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, "fs_a", g);
        cyc(1, 32'h510, 4'h2, 0, 32'h0, 4'h0, 1, 0, 1, 0, 0, 0, "fs_flush", g);
        cyc(1, 32'h510, 4'h2, 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, "fs_after", g);
        chk_eq("fs_after_tag", g, 0);
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0, 1, "fs_rsp", g);

        // Reset with three tags in flight; stale response afterwards is dropped.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h600 + i * 16, 4'(i + 8), 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, $sformatf("mr%0d", i), g);
        end
        reset = 1'b0;
        dmd_req = '{valid: 1'b1, addr: 32'h700, id: 4'h6};
        for (int i = 0; i < 4; i++) m_alloc[i] = 1'b0;
        @(negedge clk);
        chk_eq("mr_rst_busy", busy, 0);
        chk_eq("mr_rst_dgnt", dmd_gnt, 0);
        chk_eq("mr_rst_arb", arb_req.valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 1, 0, 0, 0, 0, "mr_rsp", g);
        chk_eq("mr_busy", busy, 0);
        cyc(1, 32'h700, 4'h6, 0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, "mr_new", g);
        chk_eq("mr_new_tag", g, 0);
        cyc(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0, 1, "mr_new_rsp", g);

        chk_eq("rsp_q_empty", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
